acl_rxbuf_reader: RTL

//  Read sequencer for the ping-pong RX ACL payload buffer. When the buffer controller reports a filled half
//  (regi_aclrxbufempty low), it drains the half word-by-word over bsm_addr/bsm_cs and streams each word to the

---
 rtl/acl_rxbuf_reader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/acl_rxbuf_reader.sv
// ---------------------------------------------------------------------------
// acl_rxbuf_reader
//   Read sequencer for the ping-pong RX ACL payload buffer. When the buffer
//   controller reports a filled half, this block reads the half one word at a
//   time from the SRAM and streams each word to the host over valid/ready.
//   After the host takes a word, it sends one consumed pulse back to the buffer
//   controller. The pulse for the last word releases the half. A zero-length
//   half, or a host flush, is released with a single pulse at address 0xFF.
//
// Ports
//   clk_6M, rstz         clock; asynchronous active-low reset
//   regi_aclrxbufempty   1 = no filled half pending
//   rx_lenByte           byte length of the half on the read side
//   bsm_dout             SRAM read data, valid the cycle after bsm_cs
//   host_ready           host accepts host_data this cycle
//   host_flush           one-cycle pulse: drop the rest of the packet
//   bsm_addr, bsm_cs     SRAM read address / read chip select
//   bsm_valid_p          word-consumed pulse to the buffer controller
//   host_valid/data/last/nbytes  host word stream (byte 0 in [7:0])
//   rd_busy              sequencer is not IDLE
//   dbg_state            current FSM state, for observation only
//
// Host handshake: a word transfers on every clock edge where host_valid and
// host_ready are both high. host_valid, host_data, host_last and host_nbytes
// stay stable from the time host_valid rises until that edge.
// ---------------------------------------------------------------------------
module acl_rxbuf_reader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = ADDR_W + 2,
  parameter int DATA_W = 32
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              regi_aclrxbufempty,
  input  logic [LEN_W-1:0]  rx_lenByte,
  input  logic [DATA_W-1:0] bsm_dout,
  input  logic              host_ready,
  input  logic              host_flush,
  output logic [ADDR_W-1:0] bsm_addr,
  output logic              bsm_cs,
  output logic              bsm_valid_p,
  output logic              host_valid,
  output logic [DATA_W-1:0] host_data,
  output logic              host_last,
  output logic [2:0]        host_nbytes,
  output logic              rd_busy,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_OUT  = 3'd3,
    S_ACK  = 3'd4,
    S_REL  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     nwords_q, nwords_d;   // up to 2**ADDR_W words
  logic [LEN_W-1:0]    len_q, len_d;

  logic [ADDR_W-1:0]   bsm_addr_q, bsm_addr_d;
  logic                bsm_cs_q, bsm_cs_d;
  logic                bsm_valid_p_q, bsm_valid_p_d;
  logic                host_valid_q, host_valid_d;
  logic [DATA_W-1:0]   host_data_q, host_data_d;
  logic                host_last_q, host_last_d;
  logic [2:0]          host_nbytes_q, host_nbytes_d;
  logic                rd_busy_q, rd_busy_d;

  logic                last_w;
  logic [2:0]          nbytes_w;

  // Current word is the final one of the packet.
  assign last_w   = ({1'b0, ptr_q} == (nwords_q - 1'b1));
  // A partial final word carries len[1:0] bytes. A multiple of 4 gives a full word.
  assign nbytes_w = !last_w                ? 3'd4 :
                    (len_q[1:0] == 2'b00) ? 3'd4 : {1'b0, len_q[1:0]};

  // Next state
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    nwords_d = nwords_q;
    len_d    = len_q;
    case (state_q)
      S_IDLE: begin
        if (!regi_aclrxbufempty) begin
          // Latch the length now. rx_lenByte changes when the halves swap.
          len_d    = rx_lenByte;
          ptr_d    = '0;
          nwords_d = {1'b0, rx_lenByte[LEN_W-1:2]}
                   + {{ADDR_W{1'b0}}, |rx_lenByte[1:0]};
          state_d  = (rx_lenByte == '0) ? S_REL : S_RD;
        end
      end
      S_RD:   state_d = host_flush ? S_REL : S_CAP;
      S_CAP:  state_d = host_flush ? S_REL : S_OUT;
      S_OUT: begin
        // A flush wins over a simultaneous ready. That word still counts as accepted.
        if (host_flush)      state_d = S_REL;
        else if (host_ready) state_d = S_ACK;
      end
      S_ACK: begin
        if (host_flush) begin
          state_d = S_REL;
        end else if (last_w) begin
          state_d = S_DONE;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_REL:  state_d = S_DONE;
      // The empty flag updates one edge after the release. Spend this cycle
      // here so a stale "not empty" does not start a second read.
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered. Each one is decoded from the state being entered,
  // so it lines up with that state.
  always_comb begin
    bsm_cs_d      = (state_d == S_RD);
    bsm_valid_p_d = (state_d == S_ACK) || (state_d == S_REL);
    bsm_addr_d    = bsm_addr_q;
    if (state_d == S_REL)
      bsm_addr_d = {ADDR_W{1'b1}};   // 0xFF satisfies any end address
    else if ((state_d == S_RD) || (state_d == S_CAP) ||
             (state_d == S_OUT) || (state_d == S_ACK))
      bsm_addr_d = ptr_d;
    host_valid_d  = (state_d == S_OUT);
    host_data_d   = (state_q == S_CAP) ? bsm_dout : host_data_q;
    host_last_d   = 1'b0;
    host_nbytes_d = 3'd0;
    if (state_d == S_OUT) begin
      host_last_d   = (state_q == S_CAP) ? last_w   : host_last_q;
      host_nbytes_d = (state_q == S_CAP) ? nbytes_w : host_nbytes_q;
    end
    rd_busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      nwords_q      <= '0;
      len_q         <= '0;
      bsm_addr_q    <= '0;
      bsm_cs_q      <= 1'b0;
      bsm_valid_p_q <= 1'b0;
      host_valid_q  <= 1'b0;
      host_data_q   <= '0;
      host_last_q   <= 1'b0;
      host_nbytes_q <= 3'd0;
      rd_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      nwords_q      <= nwords_d;
      len_q         <= len_d;
      bsm_addr_q    <= bsm_addr_d;
      bsm_cs_q      <= bsm_cs_d;
      bsm_valid_p_q <= bsm_valid_p_d;
      host_valid_q  <= host_valid_d;
      host_data_q   <= host_data_d;
      host_last_q   <= host_last_d;
      host_nbytes_q <= host_nbytes_d;
      rd_busy_q     <= rd_busy_d;
    end
  end

  assign bsm_addr    = bsm_addr_q;
  assign bsm_cs      = bsm_cs_q;
  assign bsm_valid_p = bsm_valid_p_q;
  assign host_valid  = host_valid_q;
  assign host_data   = host_data_q;
  assign host_last   = host_last_q;
  assign host_nbytes = host_nbytes_q;
  assign rd_busy     = rd_busy_q;
  assign dbg_state   = state_q;

endmodule
